ksa_swap_fsm: RTL and testbench
===============================

// Module: ksa_swap_fsm
// PURPOSE
//  RC4 key-scheduling swap loop. Runs after the S-memory init FSM has written S[i]=i.
//  Permutes the 256x8 S memory in place with the secret key:
//  j = j + S[i] + key[i mod KEY_LEN]; swap S[i], S[j].
//  Shares the s_memory port (address/data/wren/q) with the init FSM via the top-level mux.
//  Drives done when S is fully scheduled, for the downstream PRGA/decrypt stage.
// PARAMETERS
//  KEY_LEN     3  key length in bytes; secret_key width is 8*KEY_LEN
//  RD_LATENCY  1  cycles from address sampled by memory to valid mem_rd_data; legal values 1..2
// PORTS
//  clk          in   1         system clock (CLOCK_50 at top)
//  reset_n      in   1         asynchronous active-low reset
//  start        in   1         level; sampled in IDLE; asserted by top when init FSM done
//  secret_key   in   8*KEY_LEN key; byte k = secret_key[8*(KEY_LEN-k)-1 -: 8] (MSB byte is key[0])
//  mem_rd_data  in   8         s_memory q
//  mem_addr     out  8         s_memory address
//  mem_wr_data  out  8         s_memory data
//  mem_wr_en    out  1         s_memory wren
//  busy         out  1         1 in every state except IDLE and DONE
//  done         out  1         1 while in DONE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, i=0, j=0, si=0, sj=0, all outputs 0.
//   S contents are then partially permuted; top must re-run init before restarting.
//  Outputs decoded from state/i/j/si/sj registers only; no combinational path from mem_rd_data.
//  secret_key is sampled continuously and must be held stable while busy.
//  States and transitions:
//   IDLE    : addr=0, wr_en=0. start=1 -> READ_I with i=0, j=0.
//   READ_I  : addr=i, held RD_LATENCY cycles -> CAPT_I.
//   CAPT_I  : addr=i. si<=mem_rd_data; j<=(j+mem_rd_data+key[i%KEY_LEN]) mod 256 -> READ_J.
//   READ_J  : addr=j (new), held RD_LATENCY cycles -> CAPT_J.
//   CAPT_J  : addr=j. sj<=mem_rd_data -> WRITE_J.
//   WRITE_J : addr=j, wr_data=si, wr_en=1 -> WRITE_I.
//   WRITE_I : addr=i, wr_data=sj, wr_en=1.
//             i==255 -> DONE; else i<=i+1 -> READ_I.
//   DONE    : done=1, wr_en=0, addr=0. start=0 -> IDLE.
//             start held 1 stays in DONE; there is no rerun.
//  Arithmetic: i and j are 8-bit and wrap mod 256.
//   key index = i mod KEY_LEN, computed by a 0..KEY_LEN-1 counter.
//   The counter resets with i and wraps at KEY_LEN-1; no divider.
//  i==j: both reads return the same old value. Both writes store it unchanged (correct RC4).
//  Latency: 2*RD_LATENCY+4 cycles per iteration; 256*(2*RD_LATENCY+4) cycles from IDLE->READ_I
//   to first DONE cycle. RD_LATENCY=1: 1536 cycles; RD_LATENCY=2: 2048 cycles.
//  wr_en is never asserted outside WRITE_J/WRITE_I; exactly 512 write cycles per run.
// TESTING
//  1 Identity S, key 0x000000, RD_LATENCY=1.
//    -> iter0 writes addr0 data0 twice; iter2 writes addr3<-2 then addr2<-3.
//    -> Final S matches C reference model.
//  2 Identity S, key 0x000249.
//    -> Final 256 bytes match software RC4 KSA byte-for-byte.
//    -> done rises exactly 1536 cycles after start sampled.
//  3 RD_LATENCY=2 behavioural memory with 2-cycle q.
//    -> Same final S as test 2; done after 2048 cycles.
//  4 Assert reset_n=0 at iteration 100 mid WRITE_J.
//    -> All outputs 0 immediately (async); IDLE after release.
//    -> Re-init + start gives correct S.
//  5 start held 1 through DONE for 50 cycles.
//    -> done stays 1, no further wr_en; start=0 -> IDLE next cycle, done=0.
//  6 Assertion over all runs: busy&~wr_en never with wr_data change relevance.
//    -> mem_wr_en only in write states; i/j wrap 255->0 without X.

Source files
------------

// File: rtl/ksa_swap_fsm.sv
// rtl/ksa_swap_fsm.sv - RC4 key-scheduling swap loop over a shared 256x8 S memory
//
// Purpose: after S[i]=i has been written by the init FSM, permutes S in place:
//   j = j + S[i] + key[i mod KEY_LEN]; swap S[i], S[j]   for i = 0..255
// Ports:
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   start_i        level request, sampled in IDLE
//   secret_key_i   8*KEY_LEN key, MSB byte is key[0]; held stable while busy
//   mem_rd_data_i  S memory read data (q), RD_LATENCY cycles after address
//   mem_addr_o     S memory address
//   mem_wr_data_o  S memory write data
//   mem_wr_en_o    S memory write enable
//   busy_o         high in every state except IDLE and DONE
//   done_o         high while in DONE
module ksa_swap_fsm #(
    parameter int KEY_LEN    = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [8*KEY_LEN-1:0]   secret_key_i,
    input  logic [7:0]             mem_rd_data_i,
    output logic [7:0]             mem_addr_o,
    output logic [7:0]             mem_wr_data_o,
    output logic                   mem_wr_en_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int             KW       = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0]  KEY_LAST = KW'(KEY_LEN - 1);
    localparam logic [1:0]     LAT_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ_I  = 3'd1,
        ST_CAPT_I  = 3'd2,
        ST_READ_J  = 3'd3,
        ST_CAPT_J  = 3'd4,
        ST_WRITE_J = 3'd5,
        ST_WRITE_I = 3'd6,
        ST_DONE    = 3'd7
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [KW-1:0]  k_q, k_d;       // i mod KEY_LEN, stepped alongside i
    logic [1:0]     lat_q, lat_d;   // cycles spent waiting on a read
    logic [7:0]     key_byte;

    // Select key[k] without a variable part-select; k never exceeds KEY_LEN-1.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (k_q == KW'(k)) begin
                key_byte = secret_key_i[8*(KEY_LEN-k)-1 -: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            k_q     <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        si_d          = si_q;
        sj_d          = sj_q;
        k_d           = k_q;
        lat_d         = lat_q;
        mem_addr_o    = 8'd0;
        mem_wr_data_o = 8'd0;
        mem_wr_en_o   = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    lat_d   = '0;
                    state_d = ST_READ_I;
                end
            end
            ST_READ_I: begin
                mem_addr_o = i_q;
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = ST_CAPT_I;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_CAPT_I: begin
                mem_addr_o = i_q;
                si_d       = mem_rd_data_i;
                j_d        = j_q + mem_rd_data_i + key_byte;
                state_d    = ST_READ_J;
            end
            ST_READ_J: begin
                mem_addr_o = j_q;
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = ST_CAPT_J;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_CAPT_J: begin
                mem_addr_o = j_q;
                sj_d       = mem_rd_data_i;
                state_d    = ST_WRITE_J;
            end
            ST_WRITE_J: begin
                mem_addr_o    = j_q;
                mem_wr_data_o = si_q;
                mem_wr_en_o   = 1'b1;
                state_d       = ST_WRITE_I;
            end
            ST_WRITE_I: begin
                // When i==j both captures hold the same old byte, so the
                // two writes leave S[i] unchanged as RC4 requires.
                mem_addr_o    = i_q;
                mem_wr_data_o = sj_q;
                mem_wr_en_o   = 1'b1;
                if (i_q == 8'hFF) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = (k_q == KEY_LAST) ? '0 : k_q + KW'(1);
                    state_d = ST_READ_I;
                end
            end
            ST_DONE: begin
                busy_o = 1'b0;
                done_o = 1'b1;
                // No rerun: S is already permuted, init must run again first.
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb/tb_ksa_swap_fsm.sv - directed self-checking bench for ksa_swap_fsm
module tb_ksa_swap_fsm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [23:0] key = 24'h0;

    logic [7:0]  addr1, wd1, q1, addr2, wd2, q2, p2;
    logic        we1, busy1, done1, we2, busy2, done2;

    logic [7:0]  mem1 [0:255];
    logic [7:0]  mem2 [0:255];
    logic [7:0]  ref_s [0:255];
    logic [7:0]  wa_log [0:1023];
    logic [7:0]  wd_log [0:1023];
    int          wcnt1 = 0;
    int          wcnt2 = 0;
    logic        init1 = 1'b0;
    logic        init2 = 1'b0;
    logic        log_clr = 1'b0;
    int          bad_we = 0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cnt;

    always #5 clk = ~clk;

    ksa_swap_fsm #(.KEY_LEN(3), .RD_LATENCY(1)) u_dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start1), .secret_key_i(key),
        .mem_rd_data_i(q1), .mem_addr_o(addr1), .mem_wr_data_o(wd1),
        .mem_wr_en_o(we1), .busy_o(busy1), .done_o(done1)
    );

    ksa_swap_fsm #(.KEY_LEN(3), .RD_LATENCY(2)) u_dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start2), .secret_key_i(key),
        .mem_rd_data_i(q2), .mem_addr_o(addr2), .mem_wr_data_o(wd2),
        .mem_wr_en_o(we2), .busy_o(busy2), .done_o(done2)
    );

    // One-cycle synchronous RAM with init-to-identity and a write log.
    always @(posedge clk) begin
        if (init1) begin
            for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
        end else if (we1) begin
            mem1[addr1] <= wd1;
        end
        q1 <= mem1[addr1];
        if (log_clr) begin
            wcnt1 <= 0;
        end else if (we1 && reset_n) begin
            if (wcnt1 < 1024) begin
                wa_log[wcnt1] <= addr1;
                wd_log[wcnt1] <= wd1;
            end
            wcnt1 <= wcnt1 + 1;
        end
    end

    // Two-cycle RAM for the RD_LATENCY=2 instance.
    always @(posedge clk) begin
        if (init2) begin
            for (int k = 0; k < 256; k++) mem2[k] <= 8'(k);
        end else if (we2) begin
            mem2[addr2] <= wd2;
        end
        p2 <= mem2[addr2];
        q2 <= p2;
        if (log_clr) wcnt2 <= 0;
        else if (we2 && reset_n) wcnt2 <= wcnt2 + 1;
    end

    // Writes must only come from the busy write states.
    always @(negedge clk) begin
        if (reset_n) begin
            if ((we1 && (!busy1 || done1)) || (we2 && (!busy2 || done2))) bad_we <= bad_we + 1;
            if ($isunknown({addr1, wd1, we1, busy1, done1, addr2, wd2, we2, busy2, done2}))
                bad_we <= bad_we + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_ksa(input logic [23:0] k);
        logic [7:0] j, t, kb;
        for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            case (n % 3)
                0: kb = k[23:16];
                1: kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = j + ref_s[n] + kb;
            t = ref_s[n];
            ref_s[n] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    // Init memory, start, count edges from the start-sampling edge to done.
    task automatic run_dut(input int which, input string tag, input int exp_cycles);
        @(negedge clk);
        if (which == 1) init1 = 1'b1; else init2 = 1'b1;
        log_clr = 1'b1;
        @(negedge clk);
        init1 = 1'b0; init2 = 1'b0; log_clr = 1'b0;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        cnt = 0;
        while (!((which == 1) ? done1 : done2) && cnt < 4000) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_eq({tag, "_cycles"}, cnt, exp_cycles);
        check_eq({tag, "_writes"}, (which == 1) ? wcnt1 : wcnt2, 512);
    endtask

    task automatic check_mem(input int which, input string tag);
        for (int k = 0; k < 256; k++)
            check_eq($sformatf("%s_s%0d", tag, k), (which == 1) ? mem1[k] : mem2[k], ref_s[k]);
    endtask

    initial begin
        int held;
        #1;
        check_eq("rst_outs1", {addr1, wd1, we1, busy1, done1}, 0);
        check_eq("rst_outs2", {addr2, wd2, we2, busy2, done2}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Test 1: key 0
        key = 24'h000000;
        run_dut(1, "t1", 1536);
        check_eq("t1_w0", {wa_log[0], wd_log[0]}, 16'h0000);
        check_eq("t1_w1", {wa_log[1], wd_log[1]}, 16'h0000);
        check_eq("t1_w4", {wa_log[4], wd_log[4]}, 16'h0302);
        check_eq("t1_w5", {wa_log[5], wd_log[5]}, 16'h0203);
        ref_ksa(key);
        check_mem(1, "t1");
        start1 = 1'b0;
        @(posedge clk); #1;
        check_eq("t1_idle", {busy1, done1}, 0);

        // Test 2: key 0x000249; iter1 j=3, iter2 j=78
        key = 24'h000249;
        run_dut(1, "t2", 1536);
        check_eq("t2_w2", {wa_log[2], wd_log[2]}, 16'h0301);
        check_eq("t2_w3", {wa_log[3], wd_log[3]}, 16'h0103);
        check_eq("t2_w4", {wa_log[4], wd_log[4]}, 16'h4e02);
        check_eq("t2_w5", {wa_log[5], wd_log[5]}, 16'h024e);
        ref_ksa(key);
        check_mem(1, "t2");

        // Test 5: start held through DONE
        held = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done1 && !busy1) held++;
        end
        check_eq("t5_done_held", held, 50);
        check_eq("t5_no_writes", wcnt1, 512);
        @(negedge clk);
        start1 = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_idle", {busy1, done1}, 0);

        // Test 3: two-cycle memory
        run_dut(2, "t3", 2048);
        check_mem(2, "t3");
        start2 = 1'b0;

        // Test 4: reset in iteration 100 WRITE_J
        @(negedge clk);
        init1 = 1'b1; log_clr = 1'b1;
        @(negedge clk);
        init1 = 1'b0; log_clr = 1'b0; start1 = 1'b1;
        cnt = 0;
        while (!(wcnt1 == 200 && we1) && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("t4_reached_wrj", {wcnt1[15:0], we1, wd1 == mem1[addr1] ? 1'b0 : 1'b0}, {16'd200, 1'b1, 1'b0});
        reset_n = 1'b0;
        #1;
        check_eq("t4_async_outs", {addr1, wd1, we1, busy1, done1}, 0);
        start1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("t4_idle", {addr1, we1, busy1, done1}, 0);
        run_dut(1, "t4", 1536);
        check_mem(1, "t4");
        start1 = 1'b0;
        @(posedge clk); #1;

        check_eq("t6_bad_writes", bad_we, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
